i2s_rx: RTL
===========

// Module: i2s_rx
// PURPOSE
//   Serial-to-parallel I2S receiver: samples sdin on rising sck, frames words by lrck and
//   emits one DATA_WIDTH word per channel slot with a one-cycle l_vld/r_vld strobe.
//   Sits directly upstream of the per-channel latch stage (data/l_vld/r_vld contract).
// PARAMETERS
//   DATA_WIDTH  8  bits captured per slot, MSB first; extra slot bits are ignored
// PORTS
//   sck        in   1           bit clock; all logic on posedge
//   rst_n      in   1           synchronous, active-low reset
//   lrck       in   1           word select: 0 = left slot, 1 = right slot
//   sdin       in   1           serial data, MSB first
//   data       out  DATA_WIDTH  last completed word; held between strobes
//   l_vld      out  1           1-cycle strobe: data is a left word
//   r_vld      out  1           1-cycle strobe: data is a right word
//   frame_err  out  1           1-cycle strobe: slot ended before DATA_WIDTH bits
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): data=0, l_vld=r_vld=frame_err=0, bit_cnt=0, state=IDLE,
//   lrck_q <= lrck (no false edge on reset release). Reset mid-word discards the partial word.
// - Edge: edge = (lrck != lrck_q); lrck_q <= lrck each cycle. slot_ch <= lrck on edge.
// - FSM states:
//   - IDLE: wait for first edge, so no partial first word; on edge -> DELAY.
//   - DELAY: one-bit I2S skip (sdin ignored) -> SHIFT, bit_cnt=0.
//   - SHIFT: shreg <= {shreg, sdin}, bit_cnt++.
//     - DATA_WIDTH-th bit sampled -> WAIT. Next cycle: data <= word, strobe per slot_ch.
//   - WAIT: sdin ignored until next edge.
//   - Edge in DELAY/SHIFT/WAIT restarts the slot -> DELAY, bit_cnt=0.
// - Latency: strobe and data update 1 sck after the edge sampling the last bit.
//   Exactly one of l_vld/r_vld per completed word; never both.
// - Short slot (edge in SHIFT/DELAY with bit_cnt < DATA_WIDTH): word discarded, no vld,
//   frame_err=1 the next cycle, new slot starts normally.
// - Simultaneous (edge at the cycle the DATA_WIDTH-th bit is sampled, slot==DATA_WIDTH in
//   I2S mode): sampled bit completes the word (strobed, no frame_err), then new slot -> DELAY.
// - bit_cnt is $clog2(DATA_WIDTH+1) bits, saturates at DATA_WIDTH; never wraps.
// CONFIGURATION
//   I2S_RX_LJ_EN defined: left-justified format; DELAY skipped, edge -> SHIFT directly, and
//     the bit sampled at the edge cycle is the MSB.
//     Simultaneous case: the word completes and the edge bit is the new word's MSB.
//   Undefined (default): standard I2S, one-bit delay via DELAY as above.
// STRUCTURE
//   i2s_defs.vh: localparams ST_IDLE/ST_DELAY/ST_SHIFT/ST_WAIT (2-bit), CH_LEFT=0, CH_RIGHT=1.
//   Sub-module i2s_lrck_det: lrck_q register with reset preload, edge and slot_ch outputs.
//   Shift register, counter and FSM stay in i2s_rx.
// TESTING (DATA_WIDTH=8 unless noted)
// - 16-bit slots, left 0xA5 / right 0x3C, I2S timing:
//   l_vld=1, data=0xA5 on cycle after 8th bit; then r_vld=1, data=0x3C; frame_err stays 0.
// - lrck=1 held through reset release, then toggles:
//   no strobe until first full slot after first edge; all outputs 0 during reset.
// - Slot of 5 bits, then normal 16-bit slot:
//   frame_err pulses once, no vld for short slot; following word received correctly.
// - 8-bit slots, continuous alternating 0x81/0x7E:
//   every word strobed, alternating l_vld/r_vld, no frame_err.
// - rst_n low for 1 cycle after 4 bits of left 0xFF:
//   no strobe for that word; data=0; receiver resyncs at next edge.
// - I2S_RX_LJ_EN build, 8-bit slots, 0xC3 left:
//   MSB taken at edge cycle; l_vld with data=0xC3 after 8th bit.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared FSM state encoding and channel codes for the I2S receiver.
package i2s_rx_pkg;
  // ST_DELAY names the I2S skip bit. That bit is always the lrck edge cycle, so the FSM never holds it as a registered state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_lrck_det.sv
// i2s_lrck_det: lrck edge detector and slot channel register.
// lrck_q loads during reset, so no edge is seen when reset is released.
module i2s_lrck_det
  import i2s_rx_pkg::*;
(
  input  logic sck,
  input  logic rst_n,
  input  logic lrck,
  output logic lr_edge,
  output logic slot_ch
);
  logic lrck_q;
  assign lr_edge = lrck != lrck_q;
  always_ff @(posedge sck) begin
    lrck_q  <= lrck;
    slot_ch <= !rst_n ? CH_LEFT : lr_edge ? lrck : slot_ch;
  end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial-to-parallel receiver. It emits one DATA_WIDTH word per lrck slot.
// Define I2S_RX_LJ_EN to select left-justified framing. The default is standard I2S with a one-bit delay.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sck,
  input  logic                  rst_n,
  input  logic                  lrck,
  input  logic                  sdin,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  l_vld,
  output logic                  r_vld,
  output logic                  frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
`ifdef I2S_RX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif
  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  lr_edge, slot_ch, pend, pend_ch, last, old_bit, new_bit;
  i2s_lrck_det u_det (
    .sck     (sck),
    .rst_n   (rst_n),
    .lrck    (lrck),
    .lr_edge (lr_edge),
    .slot_ch (slot_ch)
  );
  // In I2S, the edge-cycle bit is the LSB of the old slot. In LJ, it is the MSB of the new slot.
  always_comb begin
    last    = bit_cnt == CW'(DATA_WIDTH - 1);
    old_bit = state == ST_SHIFT && !(LJ && lr_edge);
    new_bit = LJ && lr_edge;
  end
  always_ff @(posedge sck)
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      pend      <= 1'b0;
      pend_ch   <= CH_LEFT;
      data      <= '0;
      l_vld     <= 1'b0;
      r_vld     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      l_vld     <= pend && pend_ch == CH_LEFT;
      r_vld     <= pend && pend_ch == CH_RIGHT;
      data      <= pend ? shreg : data;
      pend      <= 1'b0;
      frame_err <= 1'b0;
      if (old_bit || new_bit) shreg <= {shreg[DATA_WIDTH-2:0], sdin};
      if (old_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (last) begin
          pend    <= 1'b1;
          pend_ch <= slot_ch;
          state   <= ST_WAIT;
        end
      end
      if (lr_edge) begin
        frame_err <= state == ST_SHIFT && !(old_bit && last);
        state     <= ST_SHIFT;
        bit_cnt   <= new_bit ? CW'(1) : '0;
      end
    end
endmodule
